// File: rtl/fifo_refill_ctrl.sv
// Keeps the pixel line FIFO topped up from frame memory in fixed-length read bursts.
// Latency: request one cycle after free space is seen in IDLE; beats pass to the FIFO combinationally.
// Backpressure: no new burst without BURST_LEN free words; define REFILL_STATS_EN for burst_count.
module fifo_refill_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 20,
  parameter int FIFO_SIZE   = 64,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 307200,
  parameter int BASE_ADDR   = 0,
  parameter int SIZE_WIDTH  = $clog2(FIFO_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rdvalid,
  input  logic [DATA_WIDTH-1:0] mem_rddata,
  output logic                  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_wrdone,
  input  logic [SIZE_WIDTH-1:0] fifo_num_free,
  output logic                  busy,
  output logic                  overflow
`ifdef REFILL_STATS_EN
  ,
  output logic [15:0]           burst_count
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   FRAME_END  = (ADDR_WIDTH + 1)'(BASE_ADDR + FRAME_WORDS);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [SIZE_WIDTH-1:0] BURST_FREE = SIZE_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [ADDR_WIDTH:0]   addr_step;
  logic [BEAT_W-1:0]     beat, beat_nxt;
  logic                  rewind_pend, rewind_nxt;
  logic                  burst_done;

  assign addr_step = {1'b0, addr} + (ADDR_WIDTH + 1)'(BURST_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= BASE;
      beat        <= '0;
      rewind_pend <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      beat        <= beat_nxt;
      rewind_pend <= rewind_nxt;
      if (fifo_wren && !fifo_wrdone)
        overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    beat_nxt   = beat;
    rewind_nxt = rewind_pend;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start)
          addr_nxt = BASE;
        else if (enable && fifo_num_free >= BURST_FREE)
          state_nxt = REQ;
      end
      REQ: begin
        // An ack in the same cycle as frame_start commits the burst; rewind after it.
        if (mem_ack) begin
          state_nxt = DATA;
          beat_nxt  = '0;
          if (frame_start)
            rewind_nxt = 1'b1;
        end else if (frame_start) begin
          state_nxt = IDLE;
          addr_nxt  = BASE;
        end
      end
      DATA: begin
        if (frame_start)
          rewind_nxt = 1'b1;
        if (mem_rdvalid) begin
          beat_nxt = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            state_nxt  = IDLE;
            beat_nxt   = '0;
            burst_done = 1'b1;
            rewind_nxt = 1'b0;
            if (rewind_pend || frame_start || addr_step == FRAME_END)
              addr_nxt = BASE;
            else
              addr_nxt = addr_step[ADDR_WIDTH-1:0];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req     = (state == REQ);
  assign mem_addr    = addr;
  assign fifo_wren   = (state == DATA) && mem_rdvalid;
  assign fifo_wrdata = fifo_wren ? mem_rddata : '0;
  assign busy        = (state != IDLE);

`ifdef REFILL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || frame_start)
      burst_count <= '0;
    else if (burst_done && burst_count != 16'hFFFF)
      burst_count <= burst_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_refill_ctrl.sv
// Directed bench for fifo_refill_ctrl with a write-data scoreboard and a small frame.
module tb_fifo_refill_ctrl;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int SW = 7;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          frame_start;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_rdvalid;
  logic [DW-1:0] mem_rddata;
  logic          fifo_wren;
  logic [DW-1:0] fifo_wrdata;
  logic          fifo_wrdone;
  logic [SW-1:0] fifo_num_free;
  logic          busy;
  logic          overflow;
`ifdef REFILL_STATS_EN
  logic [15:0]   burst_count;
`endif

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int exp_wr = 0;
  logic [15:0] exp_bc = '0;
  logic [DW-1:0] sb_q[$];

  fifo_refill_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_SIZE(64), .BURST_LEN(8),
    .FRAME_WORDS(64), .BASE_ADDR(0), .SIZE_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdvalid(mem_rdvalid), .mem_rddata(mem_rddata),
    .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata), .fifo_wrdone(fifo_wrdone),
    .fifo_num_free(fifo_num_free), .busy(busy), .overflow(overflow)
`ifdef REFILL_STATS_EN
    , .burst_count(burst_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: every write must match the oldest beat still expected.
  always @(negedge clk) begin
    if (fifo_wren === 1'b1) begin
      wr_count++;
      if (sb_q.size() == 0)
        chk("unexpected_write", 32'(fifo_wrdata), 32'hDEAD_BEEF);
      else
        chk("wrdata", 32'(fifo_wrdata), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_timeout", 32'(mem_req), 32'd1);
  endtask

  // fs_at: beat index (0..7) to pulse frame_start, 8 = with the ack, -1 = never.
  task automatic run_burst(input logic [AW-1:0] exp_addr, input int fs_at, input int bad_beat);
    logic [DW-1:0] d;
    wait_req();
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    mem_ack = 1'b1;
    if (fs_at == 8) begin
      frame_start = 1'b1;
      exp_bc = '0;
    end
    tick();
    mem_ack = 1'b0;
    frame_start = 1'b0;
    chk("req_dropped_after_ack", 32'(mem_req), 32'd0);
    for (int b = 0; b < 8; b++) begin
      d = 16'($urandom);
      mem_rdvalid = 1'b1;
      mem_rddata = d;
      sb_q.push_back(d);
      fifo_wrdone = (b != bad_beat);
      if (b == fs_at) begin
        frame_start = 1'b1;
        exp_bc = '0;
      end
      tick();
      frame_start = 1'b0;
      fifo_wrdone = 1'b1;
    end
    mem_rdvalid = 1'b0;
    exp_wr += 8;
    if (exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
    chk("idle_gap_busy", 32'(busy), 32'd0);
    chk("idle_gap_req", 32'(mem_req), 32'd0);
    chk("write_count", 32'(wr_count), 32'(exp_wr));
`ifdef REFILL_STATS_EN
    chk("burst_count", 32'(burst_count), 32'(exp_bc));
`endif
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    frame_start = 1'b0;
    mem_ack = 1'b0;
    mem_rdvalid = 1'b0;
    mem_rddata = '0;
    fifo_wrdone = 1'b1;
    fifo_num_free = '0;
    repeat (3) tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_wren", 32'(fifo_wren), 32'd0);
`ifdef REFILL_STATS_EN
    chk("rst_burst_count", 32'(burst_count), 32'd0);
`endif

    // First request one cycle after release with room in the FIFO.
    reset = 1'b0;
    enable = 1'b1;
    fifo_num_free = 7'd64;
    tick();
    chk("req_cycle2", 32'(mem_req), 32'd1);
    run_burst(20'd0, -1, -1);

    // Seven free words is one short of a burst.
    fifo_num_free = 7'd7;
    repeat (5) tick();
    chk("free7_no_req", 32'(mem_req), 32'd0);
    fifo_num_free = 7'd8;
    tick();
    chk("free8_req", 32'(mem_req), 32'd1);
    fifo_num_free = 7'd64;
    run_burst(20'd8, -1, -1);

    // Walk the rest of the frame and wrap.
    for (int a = 16; a < 64; a += 8)
      run_burst(20'(a), -1, -1);
    run_burst(20'd0, -1, -1);

    // frame_start while requesting, before the ack.
    wait_req();
    chk("pre_cancel_addr", 32'(mem_addr), 32'd8);
    frame_start = 1'b1;
    exp_bc = '0;
    tick();
    frame_start = 1'b0;
    chk("cancel_req_drop", 32'(mem_req), 32'd0);
    chk("cancel_addr", 32'(mem_addr), 32'd0);
    run_burst(20'd0, -1, -1);

    // frame_start coincident with ack: burst runs, then rewind.
    run_burst(20'd8, 8, -1);
    for (int a = 0; a < 40; a += 8)
      run_burst(20'(a), -1, -1);
    // frame_start mid-burst at address 40.
    run_burst(20'd40, 3, -1);
    run_burst(20'd0, -1, -1);

    // Rejected write on beat 3.
    run_burst(20'd8, -1, 3);
    chk("overflow_set", 32'(overflow), 32'd1);
    run_burst(20'd16, -1, -1);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a burst.
    wait_req();
    chk("pre_reset_addr", 32'(mem_addr), 32'd24);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rdvalid = 1'b1;
      mem_rddata = 16'(16'hA000 + b);
      sb_q.push_back(16'(16'hA000 + b));
      tick();
    end
    exp_wr += 4;
    mem_rdvalid = 1'b0;
    reset = 1'b1;
    tick();
    mem_rdvalid = 1'b1;
    mem_rddata = 16'h5555;
    #1;
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_wren", 32'(fifo_wren), 32'd0);
    chk("mid_reset_addr", 32'(mem_addr), 32'd0);
    chk("mid_reset_overflow", 32'(overflow), 32'd0);
    chk("mid_reset_req", 32'(mem_req), 32'd0);
    exp_bc = '0;
`ifdef REFILL_STATS_EN
    chk("mid_reset_burst_count", 32'(burst_count), 32'd0);
`endif
    tick();
    mem_rdvalid = 1'b0;
    reset = 1'b0;
    run_burst(20'd0, -1, -1);
    run_burst(20'd8, -1, -1);
    chk("overflow_after_reset", 32'(overflow), 32'd0);

    tick();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
